// File: rtl/pulse_meter.sv
// Measures period (rise-to-rise) and high width of an asynchronous pulse train, with loss-of-signal timeout.
// Optional deglitch filter on the synchronised input: define PULSE_METER_FILTER_EN.
module pulse_meter #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 24000000,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] width,
  output logic             valid,
  output logic             timeout
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("pulse_meter: TIMEOUT must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("pulse_meter: FILTER_LEN must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_reg, state_next;
  logic             s1_reg, s2_reg, s3_reg;
  logic             lvl;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] width_reg, width_next;
  logic             valid_reg, valid_next;
  logic             timeout_reg, timeout_next;
  logic             cnt_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= in;
      s2_reg <= s1_reg;
    end
  end

`ifdef PULSE_METER_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          filt_reg;
  logic [FW-1:0] stab_reg;

  // Level follows s2 only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_reg <= 1'b0;
      stab_reg <= '0;
    end else if (s2_reg == filt_reg) begin
      stab_reg <= '0;
    end else if (stab_reg == FW'(FILTER_LEN - 1)) begin
      filt_reg <= s2_reg;
      stab_reg <= '0;
    end else begin
      stab_reg <= stab_reg + 1'b1;
    end
  end

  assign lvl = filt_reg;
`else
  assign lvl = s2_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3_reg <= 1'b0;
    else        s3_reg <= lvl;
  end

  assign rise        = lvl & ~s3_reg;
  assign fall        = ~lvl & s3_reg;
  assign cnt_expired = (cnt_reg >= WIDTH'(TIMEOUT));

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    period_next  = period_reg;
    width_next   = width_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next   = HIGH;
          cnt_next     = WIDTH'(1);
          hi_next      = WIDTH'(1);
          timeout_next = 1'b0;
        end
      end
      HIGH: begin
        if (cnt_expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt_reg);
          if (fall) state_next = LOW;
          else      hi_next    = sat_inc(hi_reg);
        end
      end
      LOW: begin
        // A rise coinciding with expiry still counts as a valid measurement.
        if (rise) begin
          state_next  = HIGH;
          period_next = cnt_reg;
          width_next  = hi_reg;
          valid_next  = 1'b1;
          cnt_next    = WIDTH'(1);
          hi_next     = WIDTH'(1);
        end else if (cnt_expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      period_reg  <= '0;
      width_reg   <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      period_reg  <= period_next;
      width_reg   <= width_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  assign period  = period_reg;
  assign width   = width_reg;
  assign valid   = valid_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: expected period/width are queued at each driven rise
// and compared against every valid strobe.
module tb_pulse_meter;
  localparam int W  = 16;
  localparam int TO = 120;
  localparam int FL = 4;
`ifdef PULSE_METER_FILTER_EN
  localparam int ARM_LAT = 3 + FL;
  localparam int T2_H    = 4;
  localparam int T2_P    = 9;
`else
  localparam int ARM_LAT = 3;
  localparam int T2_H    = 1;
  localparam int T2_P    = 7;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in;
  logic [W-1:0] period, width;
  logic         valid, timeout;

  pulse_meter #(.WIDTH(W), .TIMEOUT(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in(in),
    .period(period), .width(width), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int qp[$];
  int qw[$];
  bit armed   = 1'b0;
  int prev_p  = 0;
  int prev_h  = 0;
  int cyc     = 0;
  int last_valid_cyc = 0;
  int last_p  = 0;
  int last_w  = 0;
  bit chk_to  = 1'b0;
  bit to_d    = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int p, input int w);
    qp.push_back(p);
    qw.push_back(w);
    $display("[TB] push expect period=%0d width=%0d", p, w);
  endtask

  // One high/low pulse; the interval begun by the previous rise is published at this rise.
  task automatic pulse(input int h, input int l);
    if (armed) push(prev_p, prev_h);
    in = 1'b1;
    repeat (h) @(negedge clk);
    in = 1'b0;
    repeat (l) @(negedge clk);
    armed  = (h + l <= TO);
    prev_p = h + l;
    prev_h = h;
  endtask

  // Period 20 / high 8 with a 2-cycle low glitch inside the high phase.
  task automatic glitch_pulse();
`ifdef PULSE_METER_FILTER_EN
    if (armed) push(prev_p, prev_h);
    in = 1'b1; repeat (4) @(negedge clk);
    in = 1'b0; repeat (2) @(negedge clk);
    in = 1'b1; repeat (2) @(negedge clk);
    in = 1'b0; repeat (12) @(negedge clk);
    armed  = 1'b1;
    prev_p = 20;
    prev_h = 8;
`else
    pulse(4, 2);
    pulse(2, 12);
`endif
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n && valid) begin
      if (qp.size() == 0) begin
        check("unexpected_valid_queue", qp.size(), 1);
      end else begin
        int ep, ew;
        ep = qp.pop_front();
        ew = qw.pop_front();
        $display("[TB] valid period=%0d width=%0d (exp %0d/%0d)", period, width, ep, ew);
        check("period", period, ep);
        check("width", width, ew);
        check("timeout_at_valid", timeout, 0);
        last_valid_cyc = cyc;
        last_p = ep;
        last_w = ew;
      end
    end
    if (rst_n && timeout && !to_d && chk_to) begin
      $display("[TB] timeout after %0d cycles", cyc - last_valid_cyc);
      check("timeout_distance", cyc - last_valid_cyc, TO);
      check("period_hold", period, last_p);
      check("width_hold", width, last_w);
      chk_to = 1'b0;
    end
    to_d = timeout;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_width", width, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Square wave 10/4, five periods.
    repeat (5) pulse(4, 6);
    // Mixed interval, then the faster train.
    pulse(4, T2_P - 4);
    repeat (4) pulse(T2_H, T2_P - T2_H);

    // Period exactly TO is still measured; then silence until timeout.
    pulse(4, TO - 4);
    chk_to = 1'b1;
    pulse(4, 200);
    check("timeout_armed_seen", chk_to, 0);
    check("timeout_level", timeout, 1);
    // Next rise clears timeout and only re-arms.
    in = 1'b1;
    repeat (ARM_LAT - 1) @(negedge clk);
    check("timeout_before_rise", timeout, 1);
    @(negedge clk);
    check("timeout_cleared", timeout, 0);
    repeat (8 - ARM_LAT) @(negedge clk);
    in = 1'b0;
    repeat (6) @(negedge clk);
    armed = 1'b1; prev_p = 14; prev_h = 8;
    pulse(4, 6);

    // Reset in the middle of a high phase with period 100.
    pulse(30, 70);
    pulse(30, 70);
    if (armed) push(prev_p, prev_h);
    in = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_period", period, 0);
    check("async_rst_width", width, 0);
    check("async_rst_valid", valid, 0);
    in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    pulse(30, 70);
    pulse(30, 70);
    pulse(30, 70);

    // Glitched pulse train.
    repeat (4) glitch_pulse();
    check("queue_drain_mid", qp.size(), 0);

    // Input held high through reset release: arms but never publishes.
    rst_n = 1'b0;
    in    = 1'b1;
    repeat (2) @(negedge clk);
    armed = 1'b0;
    rst_n = 1'b1;
    repeat (ARM_LAT + TO - 1) @(negedge clk);
    check("const_high_no_timeout_yet", timeout, 0);
    @(negedge clk);
    check("const_high_timeout", timeout, 1);
    repeat (50) @(negedge clk);
    check("const_high_timeout_hold", timeout, 1);
    check("queue_drain_end", qp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
